// File: rtl/i281_pkg.sv
// Shared i281 definitions: fetch FSM states, default code address width,
// and the instruction word layout used by fetch and decode stages.
package i281_pkg;

  localparam int PC_W_DEFAULT = 6;

  // Instruction word field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RX_HI  = 11;
  localparam int RX_LO  = 10;
  localparam int RY_HI  = 9;
  localparam int RY_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    ISSUE   = 2'd3
  } fetch_state_t;

  // Packed view of a 16-bit code word; field order matches the positions above
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/fetch_multicycle_if.sv
// Fetch bus: code memory port, opcode-stage handshake and fetch status.
// master = fetch sequencer, slave = code memory / opcode stage side.
//   run, code_data, trigger, pc_load, pc_offset : into the sequencer
//   code_addr, opcode/immediate, instr_valid, pc, busy : out of the sequencer
interface fetch_multicycle_if #(
  parameter int PC_W = i281_pkg::PC_W_DEFAULT
);
  logic            run;
  logic [PC_W-1:0] code_addr;
  logic [15:0]     code_data;
  logic            opcode_next_instruction_trigger;
  logic            pc_load;
  logic [7:0]      pc_offset;
  logic [7:0]      output_to_multicycle_opcode;
  logic [7:0]      immediate;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            busy;

  modport master (
    input  run, code_data, opcode_next_instruction_trigger, pc_load, pc_offset,
    output code_addr, output_to_multicycle_opcode, immediate, instr_valid, pc, busy
  );

  modport slave (
    output run, code_data, opcode_next_instruction_trigger, pc_load, pc_offset,
    input  code_addr, output_to_multicycle_opcode, immediate, instr_valid, pc, busy
  );
endinterface

// File: rtl/fetch_multicycle_pc_next_unit.sv
// Combinational next-PC: pc + 1, or pc + 1 + sext(pc_offset) when pc_load.
// Result wraps modulo 2^PC_W.
//   pc        : current PC
//   pc_load   : select relative branch
//   pc_offset : signed 8-bit branch offset
//   pc_next   : next PC
module pc_next_unit #(
  parameter int PC_W = 6
) (
  input  logic [PC_W-1:0] pc,
  input  logic            pc_load,
  input  logic [7:0]      pc_offset,
  output logic [PC_W-1:0] pc_next
);
  // Size cast of a signed value sign-extends for wide PCs and truncates for
  // narrow ones; either way the sum is correct modulo 2^PC_W.
  assign pc_next = pc + PC_W'(1) + (pc_load ? PC_W'(signed'(pc_offset)) : '0);
endmodule

// File: rtl/fetch_multicycle.sv
// i281 multicycle instruction fetch sequencer. Owns the PC, reads code memory
// (one-cycle read latency), and holds opcode/immediate bytes until the opcode
// stage pulses its next-instruction trigger.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : fetch_multicycle_if master (memory port, handshake, status)
module fetch_multicycle
  import i281_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  fetch_multicycle_if.master bus
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic [7:0]      opc_q;
  logic [7:0]      imm_q;
  logic            vld_q;
  instr_t          word;

  assign word = bus.code_data;

  pc_next_unit #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc_q),
    .pc_load   (bus.pc_load),
    .pc_offset (bus.pc_offset),
    .pc_next   (pc_nxt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      opc_q <= '0;
      imm_q <= '0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (bus.run) state <= FETCH;
        // Memory samples code_addr on this edge; data is valid in CAPTURE
        FETCH:   state <= CAPTURE;
        CAPTURE: begin
          opc_q <= {word.opcode, word.rx, word.ry};
          imm_q <= word.imm;
          vld_q <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          // run dropping here only stops the next fetch, never the held word
          if (bus.opcode_next_instruction_trigger) begin
            vld_q <= 1'b0;
            pc_q  <= pc_nxt;
            state <= bus.run ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code_addr                   = pc_q;
  assign bus.pc                          = pc_q;
  assign bus.output_to_multicycle_opcode = opc_q;
  assign bus.immediate                   = imm_q;
  assign bus.instr_valid                 = vld_q;
  assign bus.busy                        = (state != IDLE);

endmodule

// File: tb/tb_fetch_multicycle.sv
// Self-checking bench for fetch_multicycle: synchronous code memory model,
// scoreboard queue of expected instructions, monitor on instr_valid rise.
module tb_fetch_multicycle;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] imm;
    logic [5:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  logic [15:0] mem [64];
  exp_t sb [$];
  int checks   = 0;
  int failures = 0;
  logic prev_v = 1'b0;

  fetch_multicycle_if #(.PC_W(6)) bus ();

  fetch_multicycle #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency code memory
  always @(posedge clk) bus.code_data <= mem[bus.code_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] p);
    exp_t e;
    e.opc = mem[p][15:8];
    e.imm = mem[p][7:0];
    e.pc  = p;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] off, input logic [5:0] exp_pc,
                      input string nm);
    int n;
    push(exp_pc);
    bus.opcode_next_instruction_trigger = 1'b1;
    bus.pc_load   = ld;
    bus.pc_offset = off;
    tick();
    bus.opcode_next_instruction_trigger = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_offset = 8'h00;
    chk({nm, " valid_drop"}, 32'(bus.instr_valid), 32'd0);
    chk({nm, " pc"}, 32'(bus.pc), 32'(exp_pc));
    wait_valid(n);
    chk({nm, " gap"}, n, 32'd2);
  endtask

  // Monitor: every new instruction presentation must match the scoreboard head
  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1 && prev_v !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr pc", 32'(bus.pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb opcode", 32'(bus.output_to_multicycle_opcode), 32'(e.opc));
        chk("sb imm",    32'(bus.immediate), 32'(e.imm));
        chk("sb pc",     32'(bus.pc), 32'(e.pc));
      end
    end
    prev_v = bus.instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = {8'(i) ^ 8'hC3, ~8'(i)};
    mem[0] = 16'hA35C;

    rst = 1'b0;
    bus.run = 1'b1;
    bus.opcode_next_instruction_trigger = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_offset = 8'h00;
    repeat (3) tick();

    chk("rst valid",  32'(bus.instr_valid), 32'd0);
    chk("rst busy",   32'(bus.busy), 32'd0);
    chk("rst pc",     32'(bus.pc), 32'd0);
    chk("rst opcode", 32'(bus.output_to_multicycle_opcode), 32'd0);
    chk("rst imm",    32'(bus.immediate), 32'd0);

    // First fetch after reset release: IDLE, FETCH, CAPTURE edges
    push(6'd0);
    rst = 1'b1;
    wait_valid(n);
    chk("first latency", n, 32'd3);
    chk("first busy", 32'(bus.busy), 32'd1);

    step(1'b0, 8'h00, 6'd1,  "seq0_1");
    step(1'b1, 8'h03, 6'd5,  "br1_5");
    step(1'b0, 8'h00, 6'd6,  "seq5_6");
    step(1'b1, 8'd56, 6'd63, "br6_63");
    step(1'b0, 8'h00, 6'd0,  "wrap63_0");
    step(1'b1, 8'h01, 6'd2,  "br0_2");
    step(1'b1, 8'hFC, 6'd63, "br2_m4");
    step(1'b1, 8'h80, 6'd0,  "br63_m128");
    step(1'b1, 8'h7F, 6'd0,  "br0_p127");

    // Trigger held over ISSUE, FETCH and CAPTURE edges; branch qualifiers
    // asserted during the ignored edges must not leak into pc
    push(6'd1);
    bus.opcode_next_instruction_trigger = 1'b1;
    tick();
    bus.pc_load   = 1'b1;
    bus.pc_offset = 8'h10;
    tick();
    tick();
    bus.opcode_next_instruction_trigger = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_offset = 8'h00;
    chk("hold valid", 32'(bus.instr_valid), 32'd1);
    chk("hold pc", 32'(bus.pc), 32'd1);
    tick();
    chk("hold pc later", 32'(bus.pc), 32'd1);

    // run dropped while holding an instruction
    bus.run = 1'b0;
    tick();
    tick();
    chk("norun hold valid", 32'(bus.instr_valid), 32'd1);
    chk("norun hold busy", 32'(bus.busy), 32'd1);
    bus.opcode_next_instruction_trigger = 1'b1;
    tick();
    bus.opcode_next_instruction_trigger = 1'b0;
    chk("norun pc", 32'(bus.pc), 32'd2);
    chk("norun busy", 32'(bus.busy), 32'd0);
    chk("norun valid", 32'(bus.instr_valid), 32'd0);
    repeat (5) tick();
    chk("idle busy", 32'(bus.busy), 32'd0);
    chk("idle valid", 32'(bus.instr_valid), 32'd0);
    chk("idle pc", 32'(bus.pc), 32'd2);
    push(6'd2);
    bus.run = 1'b1;
    wait_valid(n);
    chk("rerun latency", n, 32'd3);

    // Reset while in CAPTURE: the in-flight word for pc=3 must never appear
    bus.opcode_next_instruction_trigger = 1'b1;
    tick();
    bus.opcode_next_instruction_trigger = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst pc",     32'(bus.pc), 32'd0);
    chk("midrst opcode", 32'(bus.output_to_multicycle_opcode), 32'd0);
    chk("midrst imm",    32'(bus.immediate), 32'd0);
    chk("midrst valid",  32'(bus.instr_valid), 32'd0);
    chk("midrst busy",   32'(bus.busy), 32'd0);
    tick();
    push(6'd0);
    rst = 1'b1;
    wait_valid(n);
    chk("postrst latency", n, 32'd3);
    tick();

    chk("sb drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
